// File: rtl/gated_add_scheduler.sv
// gated_add_scheduler: round-robin scheduler for one shared clock-gated adder.
// Wakes the gate, issues operands, captures the sum, returns it by valid/ready.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_a/b/cin       packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/ready   result handshake
//   rsp_id/sum/cout   result owner index, sum and carry-out
//   add_enable        clock gating cell enable
//   add_a/b/cin       operands to the gated adder
//   add_sum/cout      adder result (combinational from add_a/b/cin)
//   busy              high whenever the scheduler is not idle
// Optional macro GATED_SCHED_STATS_EN adds stat_ops / stat_gated counters.
module gated_add_scheduler #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int APPROX    = 0,
  parameter int IDLE_HOLD = 2,
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  add_enable,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  busy
`ifdef GATED_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_gated
`endif
);

  localparam int HW = (IDLE_HOLD > 0) ? $clog2(IDLE_HOLD + 1) : 1;

  if (NREQ < 2 || NREQ > 16 || APPROX < 0) begin : g_param_chk
    $error("gated_add_scheduler: illegal parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAKE,
    S_ISSUE,
    S_RESP,
    S_HOLD
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  id_q;
  logic [HW-1:0]   cnt;
  logic            found;
  logic            can_acc;
  logic            accept;
  logic            rsp_hs;

  // Round-robin search: first valid index at or above ptr, wrapping.
  always_comb begin : p_rr
    int idx;
    idx   = 0;
    found = 1'b0;
    gid   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gid   = IDW'(idx);
      end
    end
  end

  assign can_acc   = (state == S_IDLE) || (state == S_HOLD);
  assign accept    = can_acc && found;
  assign req_ready = accept ? (NREQ'(1) << gid) : '0;
  assign rsp_hs    = (state == S_RESP) && rsp_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_WAKE;
      S_WAKE:  state_n = S_ISSUE;
      S_ISSUE: state_n = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_n = (IDLE_HOLD == 0) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        // A late request wins over the expiring window.
        if (accept) state_n = S_ISSUE;
        else if (cnt <= HW'(1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      id_q       <= '0;
      cnt        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      add_enable <= 1'b0;
    end else begin
      state      <= state_n;
      add_enable <= (state_n != S_IDLE);
      if (accept) begin
        add_a   <= req_a[int'(gid)*WIDTH +: WIDTH];
        add_b   <= req_b[int'(gid)*WIDTH +: WIDTH];
        add_cin <= req_cin[gid];
        id_q    <= gid;
        ptr     <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
      end
      if (state == S_ISSUE) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
      end
      if (rsp_hs) begin
        cnt <= HW'(IDLE_HOLD);
      end else if (state == S_HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = id_q;
  assign busy      = (state != S_IDLE);

`ifdef GATED_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_gated <= '0;
    end else begin
      if (rsp_hs && stat_ops != '1) begin
        stat_ops <= stat_ops + 1'b1;
      end
      if (!add_enable && stat_gated != '1) begin
        stat_gated <= stat_gated + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gated_add_scheduler.sv
// tb_gated_add_scheduler: directed plus random bench for gated_add_scheduler.
// Adder is modelled in the bench; a timing-level model checks every cycle.
module tb_gated_add_scheduler;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IH  = 2;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           add_enable;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic           busy;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b}
                             + {{W{1'b0}}, add_cin};

  gated_add_scheduler #(
    .WIDTH(W), .NREQ(N), .APPROX(0), .IDLE_HOLD(IH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_enable(add_enable), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Timing model: an op is pending from accept until its handshake;
  // the result shows from rsp_at; the gate stays open until idle_at.
  int             cyc = 0;
  int             rsp_at = -1;
  int             idle_at = 0;
  int             ptr = 0;
  logic [W-1:0]   m_a = '0;
  logic [W-1:0]   m_b = '0;
  logic           m_cin = 1'b0;
  logic [W:0]     m_res = '0;
  int             m_id = 0;
  logic [N-1:0]   acc_mask = '0;

  always @(negedge clk) begin : p_model
    int g;
    logic any, pend, v, bz;
    logic [N-1:0] er;
    cyc++;
    acc_mask = '0;
    if (rst) begin
      rsp_at = -1; idle_at = 0; ptr = 0;
      m_a = '0; m_b = '0; m_cin = 1'b0; m_res = '0; m_id = 0;
    end else begin
      pend = (rsp_at >= 0);
      v    = pend && (cyc >= rsp_at);
      bz   = pend || (cyc < idle_at);
      any  = 1'b0;
      g    = 0;
      for (int k = 0; k < N; k++) begin
        if (!any && req_valid[(ptr + k) % N]) begin
          any = 1'b1;
          g   = (ptr + k) % N;
        end
      end
      er = (!pend && any) ? (N'(1) << g) : '0;
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, v);
      chk("busy", busy, bz);
      chk("add_enable", add_enable, bz);
      chk("add_a", add_a, m_a);
      chk("add_b", add_b, m_b);
      chk("add_cin", add_cin, m_cin);
      if (v) begin
        chk("rsp_sum", rsp_sum, m_res[W-1:0]);
        chk("rsp_cout", rsp_cout, m_res[W]);
        chk("rsp_id", rsp_id, m_id);
      end
      if (v && rsp_ready) begin
        rsp_at  = -1;
        idle_at = cyc + 1 + IH;
      end else if (!pend && any) begin
        acc_mask = er;
        rsp_at   = cyc + ((cyc < idle_at) ? 2 : 3);
        m_a   = req_a[g*W +: W];
        m_b   = req_b[g*W +: W];
        m_cin = req_cin[g];
        m_res = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
        m_id  = g;
        ptr   = (g + 1) % N;
      end
    end
  end

  logic keep_all = 1'b0;
  logic rnd = 1'b0;

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_cin[i]       = c;
  endtask

  // Requesters hold until accepted, then drop (or re-arm).
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        req_valid[i] = 1'b0;
        if (keep_all) begin
          set_req(i, W'($urandom), W'($urandom), 1'($urandom_range(1)));
        end
      end
    end
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          set_req(i, W'($urandom), W'($urandom), 1'($urandom_range(1)));
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && busy; n++) tick();
    chk("drain_idle", busy, 0);
  endtask

  task automatic scen12();
    rsp_ready = 1'b1;
    set_req(1, 8'h5A, 8'h33, 1'b1);
    @(negedge clk);
    chk("s1_ready", req_ready, 4'b0010);
    chk("s1_en_t0", add_enable, 0);
    tick(); @(negedge clk);
    chk("s1_en_t1", add_enable, 1);
    tick(); @(negedge clk);
    chk("s1_novalid_t2", rsp_valid, 0);
    tick(); @(negedge clk);
    chk("s1_valid", rsp_valid, 1);
    chk("s1_sum", rsp_sum, 8'h8E);
    chk("s1_cout", rsp_cout, 0);
    chk("s1_id", rsp_id, 1);
    tick();
    set_req(2, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    chk("s2_ready", req_ready, 4'b0100);
    chk("s2_en_t0", add_enable, 1);
    tick(); @(negedge clk);
    chk("s2_en_t1", add_enable, 1);
    chk("s2_novalid", rsp_valid, 0);
    tick(); @(negedge clk);
    chk("s2_valid", rsp_valid, 1);
    chk("s2_sum", rsp_sum, 8'h00);
    chk("s2_cout", rsp_cout, 1);
    chk("s2_id", rsp_id, 2);
    tick(); @(negedge clk);
    chk("gate_h1", add_enable, 1);
    tick(); @(negedge clk);
    chk("gate_h2", add_enable, 1);
    tick(); @(negedge clk);
    chk("gate_off", add_enable, 0);
    chk("gate_busy", busy, 0);
  endtask

  logic [N-1:0] gq[$];
  logic [N-1:0] eg[5];
  logic [W-1:0] s_sum;
  logic [IDW-1:0] s_id;
  logic s_co;

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    rsp_ready = 1'b0; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", add_enable, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_id", rsp_id, 0);
    tick();
    scen12();

    // Contention from a freshly reset pointer.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    rsp_ready = 1'b1;
    keep_all = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, W'($urandom), W'($urandom), 1'($urandom_range(1)));
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("onehot", ($countones(req_ready) <= 1), 1);
      if (req_ready != '0) gq.push_back(req_ready);
      tick();
    end
    keep_all = 1'b0;
    req_valid = '0;
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("rr_count", (gq.size() >= 5), 1);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      chk("rr_order", gq[i], eg[i]);
    end
    drain();

    // Backpressure in RESP.
    tick();
    rsp_ready = 1'b0;
    set_req(3, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    for (int n = 0; n < 10 && !rsp_valid; n++) begin
      tick(); @(negedge clk);
    end
    chk("bp_reach", rsp_valid, 1);
    s_sum = rsp_sum; s_id = rsp_id; s_co = rsp_cout;
    chk("bp_sum_lit", s_sum, 8'h46);
    for (int n = 0; n < 5; n++) begin
      tick();
      if (n == 0) set_req(0, 8'h01, 8'h02, 1'b1);
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_sum, s_sum);
      chk("bp_id", rsp_id, s_id);
      chk("bp_cout", rsp_cout, s_co);
      chk("bp_noacc", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", rsp_valid, 1);
    tick(); @(negedge clk);
    chk("bp_done", rsp_valid, 0);
    chk("bp_next_acc", req_ready, 4'b0001);
    tick();
    drain();

    // Reset while the op is in ISSUE.
    tick();
    set_req(1, 8'h5A, 8'h33, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_valid", rsp_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_en", add_enable, 0);
    chk("mr_add_a", add_a, 0);
    chk("mr_sum", rsp_sum, 0);
    chk("mr_id", rsp_id, 0);
    for (int n = 0; n < 4; n++) begin
      tick(); @(negedge clk);
      chk("mr_norsp", rsp_valid, 0);
    end
    tick();
    scen12();

    // Random traffic, checked by the model each cycle.
    rnd = 1'b1;
    repeat (3000) tick();
    rnd = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (20) tick();
    chk("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gated_add_scheduler.md
Name: gated_add_scheduler

Overview:
- Arbitrates one shared clock-gated ripple-carry adder (WIDTH/APPROX adder plus clock gating cell) among NREQ requesters.
- Sequences each operation: wake the gate, issue operands, capture the sum, return it with a valid/ready handshake.
- Drives the gating cell's enable so the adder clock runs only during operations and a short idle hold window.
- Sits between requester engines (approximate multiplier partial-product stages) and the gated adder instance.

Parameters:
- WIDTH, 8, operand/sum width; passed through to the adder.
- NREQ, 4, number of requesters; legal range 2..16.
- APPROX, 0, forwarded to the adder instance; no effect on scheduler logic.
- IDLE_HOLD, 2, cycles add_enable stays high after a response before gating off; 0 means gate off immediately.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*WIDTH  packed operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  packed operand B, same packing
- req_cin  in  NREQ  per-requester carry-in
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accept
- rsp_id  out  IDW  index of the requester that owns the result; IDW = max(1, clog2(NREQ))
- rsp_sum  out  WIDTH  result sum
- rsp_cout  out  1  result carry-out
- add_enable  out  1  to the clock gating cell enable
- add_a  out  WIDTH  operand A to the adder
- add_b  out  WIDTH  operand B to the adder
- add_cin  out  1  carry-in to the adder
- add_sum  in  WIDTH  adder sum, combinational from add_a/add_b/add_cin
- add_cout  in  1  adder carry-out
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (synchronous, active-high), applied on the clock edge:
  - state=IDLE, RR pointer=0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_enable, add_a, add_b, add_cin, busy.
  - Reset mid-operation drops the in-flight result; no response is ever presented for it.
- States: IDLE, WAKE, ISSUE, RESP, HOLD.
- Accept rules:
  - Accept happens only in IDLE or HOLD when any req_valid=1.
  - req_ready[g] is combinational and high only for the granted index g in that cycle.
  - On the accept edge, req_a/b/cin[g] are captured into the operand registers, which drive add_a/add_b/add_cin, and g is captured into the id register.
- Grant is round-robin: first valid index searching upward from the pointer with wrap. After a grant, pointer=(g+1) mod NREQ.
- Transitions:
  - IDLE: accept -> WAKE; no request -> IDLE.
  - WAKE: one cycle for the gated clock to open -> ISSUE.
  - ISSUE: one cycle; add_sum/add_cout are registered into rsp_sum/rsp_cout at the end of the cycle -> RESP.
  - RESP: rsp_valid=1 and rsp_sum/rsp_cout/rsp_id held stable until rsp_ready=1. On handshake: -> HOLD with the counter loaded to IDLE_HOLD, or -> IDLE if IDLE_HOLD=0.
  - HOLD: if accept -> ISSUE (WAKE skipped, gate already open). Else the counter decrements; in the cycle it reads 1 with no request, next state is IDLE.
- add_enable = (state != IDLE), registered. It rises in the cycle after accept from IDLE.
- Latency:
  - Accept in IDLE at cycle T -> rsp_valid at T+3.
  - Accept in HOLD at T -> rsp_valid at T+2.
- No accept is possible during WAKE, ISSUE or RESP; req_ready=0 in those states. Requesters hold req_valid and operands until accepted.
- Sum and carry widths are taken verbatim from the adder; the scheduler does no arithmetic.
- A request arriving in the same cycle HOLD expires is accepted; acceptance takes priority over the timeout.
- rsp_ready asserted outside RESP is ignored.

Optional Feature:
- Macro GATED_SCHED_STATS_EN.
- When defined, adds two outputs:
  - stat_ops (32-bit): increments on each response handshake.
  - stat_gated (32-bit): increments each cycle add_enable=0.
  - Both saturate at all-ones and clear on rst.
- When undefined, these ports and counters do not exist.

Test Plan:
- Single op from IDLE (WIDTH=8): req 1 with a=0x5A, b=0x33, cin=1 -> req_ready[1] in the same cycle; rsp_valid 3 cycles later with sum=0x8E, cout=0, id=1; add_enable high from T+1.
- Back-to-back within hold (IDLE_HOLD=2): second request from req 2 arrives 1 cycle after the handshake, a=0xFF, b=0x01, cin=0 -> accepted in HOLD; rsp 2 cycles later with sum=0x00, cout=1; add_enable never drops between the two ops.
- Contention: req_valid=4'b1111 held continuously with pointer=0 -> grants in order 0,1,2,3,0; req_ready is never more than one-hot.
- Backpressure: rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp fields stable, no new accept; completes on the first cycle rsp_ready=1.
- Idle gating: after a handshake with no further requests and IDLE_HOLD=2 -> add_enable falls exactly 2 cycles after leaving RESP; busy=0 thereafter.
- Reset mid-op: rst asserted in ISSUE -> all outputs 0 the next cycle, no rsp_valid, pointer=0; a fresh request afterwards behaves exactly as in the first scenario.
